// File: rtl/dijkstra_pkg.sv
`default_nettype none
// ============================================================================
// dijkstra_pkg : shared types and helpers for the distance priority queue
// Revision     : 1.0
// ============================================================================
package dijkstra_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // All-ones pattern of the given width; callers cast to their value width.
  function automatic logic [63:0] infinity_of(input int width);
    return (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/min_lane_reduce.sv
`default_nettype none
// ============================================================================
// min_lane_reduce : combinational lowest-index minimum over LANES values
// Revision        : 1.0
// ============================================================================
module min_lane_reduce
  import dijkstra_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
) (
  input  logic [LANES*VALUE_WIDTH-1:0] lane_values,
  input  logic [INDEX_WIDTH-1:0]       base_index,
  input  logic [LANES-1:0]             lane_mask,
  output logic [INDEX_WIDTH-1:0]       min_index,
  output logic [VALUE_WIDTH-1:0]       min_value
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY = VALUE_WIDTH'(infinity_of(VALUE_WIDTH));

  // Strict less-than while walking upward keeps the lowest index on ties.
  always_comb begin
    min_value = INFINITY;
    min_index = base_index;
    for (int l = 0; l < LANES; l++) begin
      if (lane_mask[l] && (lane_values[l*VALUE_WIDTH +: VALUE_WIDTH] < min_value)) begin
        min_value = lane_values[l*VALUE_WIDTH +: VALUE_WIDTH];
        min_index = base_index + INDEX_WIDTH'(l);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dist_pq_seq.sv
`default_nettype none
// ============================================================================
// dist_pq_seq : distance table with relax port and sequential extract-min
// Revision    : 1.0
// ============================================================================
module dist_pq_seq
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int LANES       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] src_index,
  input  logic                   relax_valid,
  output logic                   relax_ready,
  input  logic [INDEX_WIDTH-1:0] relax_index,
  input  logic [VALUE_WIDTH-1:0] relax_value,
  input  logic                   extract_req,
  output logic                   extract_valid,
  input  logic                   extract_ready,
  output logic [INDEX_WIDTH-1:0] extract_index,
  output logic [VALUE_WIDTH-1:0] extract_value,
  output logic                   extract_empty,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [VALUE_WIDTH-1:0] rd_value,
  output logic [MAX_NODES-1:0]   visited_vector
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY = VALUE_WIDTH'(infinity_of(VALUE_WIDTH));
  localparam int S  = ceil_div(MAX_NODES, LANES);
  localparam int CW = $clog2(S + 1);
  localparam int NW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  state_e                   state_q, state_d;
  logic [CW-1:0]            chunk_q, chunk_d;
  logic [VALUE_WIDTH-1:0]   dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0]   dist_d [MAX_NODES];
  logic [MAX_NODES-1:0]     visited_q, visited_d;
  logic [INDEX_WIDTH-1:0]   best_idx_q, best_idx_d, lane_idx_q, lane_idx_d;
  logic [VALUE_WIDTH-1:0]   best_val_q, best_val_d, lane_val_q, lane_val_d;
  logic [VALUE_WIDTH-1:0]   rd_value_q, rd_value_d;

  logic [LANES*VALUE_WIDTH-1:0] lane_values;
  logic [LANES-1:0]             lane_mask;
  logic [INDEX_WIDTH-1:0]       chunk_base, red_idx;
  logic [VALUE_WIDTH-1:0]       red_val;
  logic                         relax_hit;

  always_comb begin
    int node;
    node        = 0;
    lane_values = {LANES{INFINITY}};
    lane_mask   = '0;
    chunk_base  = INDEX_WIDTH'(int'(chunk_q) * LANES);
    for (int l = 0; l < LANES; l++) begin
      node = int'(chunk_q) * LANES + l;
      if (node < MAX_NODES && !visited_q[node[NW-1:0]]) begin
        lane_mask[l]                             = 1'b1;
        lane_values[l*VALUE_WIDTH +: VALUE_WIDTH] = dist_q[node[NW-1:0]];
      end
    end
  end

  min_lane_reduce #(
    .LANES       (LANES),
    .INDEX_WIDTH (INDEX_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_reduce (
    .lane_values (lane_values),
    .base_index  (chunk_base),
    .lane_mask   (lane_mask),
    .min_index   (red_idx),
    .min_value   (red_val)
  );

  assign relax_hit = relax_valid && (state_q == IDLE) && (int'(relax_index) < MAX_NODES)
                     && !visited_q[relax_index[NW-1:0]]
                     && (relax_value < dist_q[relax_index[NW-1:0]]);

  // The chunk minimum is registered and merged one cycle later, so SCAN runs
  // S reduce cycles plus one drain cycle (chunk_q == S).
  always_comb begin
    dist_d     = dist_q;
    visited_d  = visited_q;
    chunk_d    = chunk_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    lane_idx_d = red_idx;
    lane_val_d = red_val;
    rd_value_d = (int'(rd_index) < MAX_NODES) ? dist_q[rd_index[NW-1:0]] : INFINITY;
    if (relax_hit) begin
      dist_d[relax_index[NW-1:0]] = relax_value;
    end
    case (state_q)
      IDLE: begin
        if (extract_req) begin
          chunk_d    = '0;
          best_idx_d = '0;
          best_val_d = INFINITY;
        end
      end
      SCAN: begin
        chunk_d = chunk_q + CW'(1);
        if (chunk_q != '0 && lane_val_q < best_val_q) begin
          best_idx_d = lane_idx_q;
          best_val_d = lane_val_q;
        end
      end
      HOLD: begin
        if (extract_ready && best_val_q != INFINITY) begin
          visited_d[best_idx_q[NW-1:0]] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (extract_req) state_d = SCAN;
      SCAN:    if (chunk_q == CW'(S)) state_d = HOLD;
      HOLD:    if (extract_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < MAX_NODES; n++) begin
        dist_q[n] <= (int'(src_index) == n) ? '0 : INFINITY;
      end
      visited_q  <= '0;
      chunk_q    <= '0;
      best_idx_q <= '0;
      best_val_q <= INFINITY;
      lane_idx_q <= '0;
      lane_val_q <= INFINITY;
      rd_value_q <= '0;
    end else begin
      dist_q     <= dist_d;
      visited_q  <= visited_d;
      chunk_q    <= chunk_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      lane_idx_q <= lane_idx_d;
      lane_val_q <= lane_val_d;
      rd_value_q <= rd_value_d;
    end
  end

  always_comb begin
    relax_ready   = (state_q == IDLE);
    extract_valid = (state_q == HOLD);
    extract_empty = (state_q == HOLD) && (best_val_q == INFINITY);
  end

  assign extract_index  = best_idx_q;
  assign extract_value  = best_val_q;
  assign rd_value       = rd_value_q;
  assign visited_vector = visited_q;

endmodule
`default_nettype wire

// File: doc/dist_pq_seq.md
Name: dist_pq_seq

Overview:
Parametrised successor to the distance-table priority queue used by the Dijkstra engine. It holds one distance per node and tracks visited nodes internally. It adds a relax port that performs a compare-and-update, replacing the plain write. It replaces the combinational min search over all nodes with a sequential scan of LANES entries per cycle and returns the minimum through a valid/ready handshake. The block sits between the graph-edge walker, which issues relaxes, and the controller, which issues extract-min.

Parameters:
MAX_NODES, 16, number of nodes and distance entries
INDEX_WIDTH, 4, node index width; must satisfy 2**INDEX_WIDTH >= MAX_NODES
VALUE_WIDTH, 8, distance width; all-ones encodes INFINITY
LANES, 4, entries compared per scan cycle; 1 <= LANES <= MAX_NODES

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
src_index  in  INDEX_WIDTH  source node, sampled while reset=1
relax_valid  in  1  relax request
relax_ready  out  1  relax accepted this cycle
relax_index  in  INDEX_WIDTH  node to relax
relax_value  in  VALUE_WIDTH  candidate distance
extract_req  in  1  start extract-min
extract_valid  out  1  result available
extract_ready  in  1  controller consumes result
extract_index  out  INDEX_WIDTH  min node (lowest index on tie)
extract_value  out  VALUE_WIDTH  min distance
extract_empty  out  1  no reachable unvisited node remains
rd_index  in  INDEX_WIDTH  debug/readback index
rd_value  out  VALUE_WIDTH  dist[rd_index], registered
visited_vector  out  MAX_NODES  visited flags

Behaviour:
- Reset (synchronous): all dist = INFINITY, except dist[src_index] = 0.
- Reset values of outputs: visited_vector=0, state=IDLE, extract_valid=0, extract_index=0, extract_value=INFINITY, extract_empty=0, rd_value=0.
- States:
  - IDLE to SCAN on extract_req.
  - SCAN to HOLD after S = ceil(MAX_NODES/LANES) cycles.
  - HOLD to IDLE on extract_ready.
  - extract_req outside IDLE is ignored.
- relax_ready = (state==IDLE). On relax_valid&&relax_ready, dist[relax_index] updates to relax_value only if relax_value < dist[relax_index], the node is not visited, and relax_index < MAX_NODES. Otherwise there is no change.
- relax_valid and extract_req in the same IDLE cycle: the relax applies on that edge and the scan observes the updated value.
- SCAN:
  - Chunk k covers entries k*LANES .. k*LANES+LANES-1. Entries >= MAX_NODES and visited entries count as INFINITY.
  - A running best (index, value) register is updated only on strict less-than, so the lowest index wins ties.
- Latency: extract_valid rises S+1 cycles after the extract_req edge. Example: 16 nodes, 4 lanes gives valid on cycle 5.
- HOLD: extract_valid=1 and outputs are stable until accepted.
  - If best value == INFINITY: extract_empty=1, extract_index=0, extract_value=INFINITY. Acceptance marks nothing.
  - Otherwise, acceptance sets visited[extract_index] on the same edge.
  - extract_valid falls the cycle after acceptance.
- Value arithmetic: compare only, unsigned, no addition inside the block. The caller saturates any sum to INFINITY.
- rd_value = dist[rd_index] with 1-cycle latency; it reflects a relax applied on the previous edge. Out-of-range rd_index returns INFINITY.
- Reset mid-SCAN or mid-HOLD aborts to IDLE immediately; no visited bit is set.

Decomposition:
- Package dijkstra_pkg: INFINITY constant (function of VALUE_WIDTH), state enum {IDLE,SCAN,HOLD}, ceil-div function for S.
- Sub-module min_lane_reduce (combinational): LANES values, a base index and a valid mask in; lowest-index minimum index and value out. Instantiated once in the scan datapath.

Test Plan:
- Reset with src_index=3, extract_req, ack -> extract_index=3, value=0, empty=0, visited_vector=16'h0008.
- After that, relax(5,7), relax(5,9), relax(2,7), extract -> index=2, value=7 (tie resolved by lowest index; 9 rejected); next extract -> index=5, value=7.
- Relax to an already-visited node 3 with value 0 -> dist[3] unchanged; rd_index=3 gives rd_value=0 one cycle later.
- All nodes visited, or only INFINITY entries remain -> extract_empty=1, value=8'hFF; visited_vector unchanged after ack.
- MAX_NODES=10, LANES=4: extract latency = 4 cycles; padded lanes never win; hold extract_ready=0 for 5 cycles -> outputs stable and relax_ready=0 throughout.
- Assert reset during SCAN with src_index=6 -> next cycle extract_valid=0, visited=0, dist[6]=0, all other entries 8'hFF.
